lector_contadores: RTL
======================

LECTOR_CONTADORES -- requirements
Module: lector_contadores

Interface
REQ-001 Parameter N_IDX SHALL be: default 5; number of counter indices scanned, 1..8.
REQ-002 Parameter TIMEOUT SHALL be: default 4; maximum number of WAIT cycles without valid before abort, 1..15.
REQ-003 Port clk SHALL be: input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be: input, 1 bit, asynchronous, active-high reset.
REQ-005 Port start SHALL be: input, 1 bit, scan request; sampled only in IDLE.
REQ-006 Port req SHALL be: output, 1 bit, registered read request to the counter block.
REQ-007 Port idx SHALL be: output, 3 bits, registered index accompanying req.
REQ-008 Port data SHALL be: input, 6 bits, count returned by the counter block.
REQ-009 Port valid SHALL be: input, 1 bit, qualifies data.
REQ-010 Ports snap0..snap4 SHALL be: outputs, 6 bits each, captured count per index; snapK exists for K < N_IDX.
REQ-011 Port total SHALL be: output, 9 bits, sum of the captured counts.
REQ-012 Ports busy, done and error SHALL be: outputs, 1 bit each; scan active, one-cycle completion pulse, and timeout flag.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and DONE.
REQ-014 In IDLE with start=1, the block SHALL clear total, all snaps and error, set the index register to 0, and go to REQ.
REQ-015 In REQ, req SHALL be 1 and idx SHALL equal the current index for exactly one cycle; the next state SHALL be WAIT.
REQ-016 In WAIT with valid=1, the block SHALL write data into the snap of the current index, add data to total (zero-extended to 9 bits, no overflow possible: 8*63 < 512), and clear the wait counter.
REQ-017 On that WAIT capture, the next state SHALL be REQ with index+1 if index < N_IDX-1; otherwise it SHALL be DONE.
REQ-018 In WAIT with valid=0, the wait counter SHALL increment; on reaching TIMEOUT, error SHALL be set to 1 and the next state SHALL be DONE, leaving the remaining snaps at 0.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-020 busy SHALL be 1 in REQ, WAIT and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored outside IDLE, and valid SHALL be ignored outside WAIT.
REQ-022 req SHALL be 0 and idx SHALL hold its last value in every state other than REQ.
REQ-023 Latency: with a responder that asserts valid one cycle after req, done SHALL go high after the 2*N_IDX-th rising edge following the edge that samples start (10 edges at default N_IDX).
REQ-024 snaps, total and error SHALL hold their values in IDLE until the next accepted start.
REQ-025 When valid coincides with the cycle in which the wait counter reaches TIMEOUT, the capture SHALL take priority and no error SHALL be raised.

Reset
REQ-026 Asserting reset SHALL immediately force: state IDLE, req=0, idx=0, busy=0, done=0, error=0, total=0, all snaps=0, index register=0, wait counter=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no done pulse; the first start after reset release SHALL begin a fresh scan from index 0.

Configuration
REQ-028 Macro MAX_TRACK_EN, when defined, SHALL add output max_val (6 bits) and output max_idx (3 bits), both reset to 0 and cleared on accepted start.
REQ-029 With MAX_TRACK_EN defined, each capture with data strictly greater than max_val SHALL update max_val and max_idx; ties SHALL keep the lower index.
REQ-030 Without MAX_TRACK_EN, the max_val and max_idx ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Counts 3,0,7,15,1 preloaded, pulse start -> req/idx 0..4 each one cycle; snaps 3,0,7,15,1; total=26; done after 10 edges; error=0.
REQ-032 Responder never asserts valid at index 2, TIMEOUT=4 -> error=1, snap0/snap1 captured, snap2..4=0, done pulses once, state returns to IDLE.
REQ-033 start held high for 20 cycles -> exactly one scan, then a second scan starts from the IDLE following DONE; start pulsed mid-scan -> no effect.
REQ-034 reset asserted during WAIT at index 3 -> all outputs 0 immediately, no done pulse; a later start rescans cleanly.
REQ-035 Responder valid delayed 3 cycles with TIMEOUT=4, and valid arriving on the timeout cycle -> capture succeeds, error=0.
REQ-036 MAX_TRACK_EN with counts 5,9,9,2,0 -> max_val=9, max_idx=1; without the macro the build has no max ports.

Source files
------------

// File: rtl/lector_contadores.sv
// Counter-readout sequencer: walks indices 0..N_IDX-1 with req/idx, snapshots each returned
// count and accumulates total; optional MAX_TRACK_EN adds max_val/max_idx of the largest capture.
module lector_contadores #(
    parameter int N_IDX   = 5,
    parameter int TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       req,
    output logic [2:0] idx,
    input  logic [5:0] data,
    input  logic       valid,
    output logic [5:0] snap0,
    output logic [5:0] snap1,
    output logic [5:0] snap2,
    output logic [5:0] snap3,
    output logic [5:0] snap4,
    output logic [8:0] total,
    output logic       busy,
    output logic       done,
    output logic       error
`ifdef MAX_TRACK_EN
    ,
    output logic [5:0] max_val,
    output logic [2:0] max_idx
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_index;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_inc;
    logic       r_req;
    logic       r_busy;
    logic       r_done;
    logic       r_error;
    logic [8:0] r_total;
    logic [5:0] r_snap [N_IDX];
    logic [5:0] w_snap_out [5];
    logic       w_accept;
    logic       w_capture;
    logic       w_abort;
    logic       w_last;

    assign w_last     = (r_index == 3'(N_IDX - 1));
    assign w_wait_inc = r_wait_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A valid on the same cycle the wait counter would expire wins over the abort.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (valid) begin
                    w_capture    = 1'b1;
                    w_state_next = w_last ? S_DONE : S_REQ;
                end else if (w_wait_inc == 4'(TIMEOUT)) begin
                    w_abort      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_req  <= (w_state_next == S_REQ);
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_wait_cnt <= '0;
            r_error    <= 1'b0;
            r_total    <= '0;
        end else begin
            if (w_accept) begin
                r_index    <= '0;
                r_wait_cnt <= '0;
                r_error    <= 1'b0;
                r_total    <= '0;
            end else if (w_capture) begin
                r_wait_cnt <= '0;
                r_total    <= r_total + {3'b000, data};
                if (!w_last) begin
                    r_index <= r_index + 3'd1;
                end
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= w_wait_inc;
                if (w_abort) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_IDX; gi++) begin : g_snap
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_snap[gi] <= '0;
                end else if (w_accept) begin
                    r_snap[gi] <= '0;
                end else if (w_capture && (r_index == 3'(gi))) begin
                    r_snap[gi] <= data;
                end
            end
        end

        for (gi = 0; gi < 5; gi++) begin : g_snap_out
            if (gi < N_IDX) begin : g_used
                assign w_snap_out[gi] = r_snap[gi];
            end else begin : g_unused
                assign w_snap_out[gi] = '0;
            end
        end
    endgenerate

`ifdef MAX_TRACK_EN
    logic [5:0] r_max_val;
    logic [2:0] r_max_idx;

    // Strictly-greater update keeps the lowest index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_accept) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_capture && (data > r_max_val)) begin
            r_max_val <= data;
            r_max_idx <= r_index;
        end
    end

    assign max_val = r_max_val;
    assign max_idx = r_max_idx;
`endif

    assign req   = r_req;
    assign idx   = r_index;
    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;
    assign total = r_total;
    assign snap0 = w_snap_out[0];
    assign snap1 = w_snap_out[1];
    assign snap2 = w_snap_out[2];
    assign snap3 = w_snap_out[3];
    assign snap4 = w_snap_out[4];

endmodule
